seg7_scan_display: RTL and testbench

- Downstream consumer of the operand-entry stage: takes a 32-bit value (operand A, operand B or ALU result) and shows it as 8 hex digits on the board's multiplexed, common-anode 7-segment display.
- Scans one digit at a time and takes a snapshot of the value at each frame start, so a digit never shows a half-updated value.
- Blinks the nibble currently being edited, optionally blanks leading zeros, and drives per-digit decimal points.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 12 +
 rtl/seg7_scan_display.sv | 137 +++++++++++++
 tb/tb_seg7_scan_display.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan display.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational table lookup.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit common-anode hex display driver.
// Frame snapshot, leading-zero blanking, edit-digit blink, per-digit dp.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_HALF = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic [2:0]  sel,
    input  logic        blink_en,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [PW-1:0] pre;
    logic          tick;
    digit_idx_t    idx;
    logic [31:0]   snap;
    logic [FW-1:0] fcnt;
    logic          blink_phase;

    logic          frame_first;
    logic          frame_last;
    logic [31:0]   src;
    logic [3:0]    nib;
    logic [6:0]    hex_seg;
    logic [7:0]    lz_zero;
    logic          is_sel;
    logic          blink_off;
    logic          blanked;
    logic          dp_n;
    logic [7:0]    seg_next;
    logic [7:0]    an_next;

    assign tick        = (pre == PW'(SCAN_DIV - 1));
    assign frame_first = tick && (idx == 3'd0);
    assign frame_last  = tick && (idx == 3'd7);

    // Prescaler: one tick per digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end

    // Digit index names the digit the next tick will drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (tick) begin
            idx <= idx + 3'd1;
        end
    end

    // Snapshot the value once per frame so a digit never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (frame_first) begin
            snap <= data;
        end
    end

    // Blink phase flips after BLINK_HALF completed frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt        <= '0;
            blink_phase <= 1'b0;
        end else if (frame_last) begin
            if (fcnt == FW'(BLINK_HALF - 1)) begin
                fcnt        <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Frame start digit decodes the freshly loaded value, not the stale one.
    always_comb begin
        src = frame_first ? data : snap;
        nib = src[{idx, 2'b00} +: 4];
        for (int i = 0; i < 8; i++) begin
            lz_zero[i] = ((src >> (4 * i)) == 32'd0);
        end
    end

    hex_to_seg7 u_hex (
        .nib (nib),
        .seg (hex_seg)
    );

    // Per-slot pattern: blink-off beats blanking beats normal decode.
    always_comb begin
        is_sel    = (idx == sel);
        blink_off = blink_en && blink_phase && is_sel;
        blanked   = blank_lz && (idx != 3'd0) && lz_zero[idx]
                    && !(blink_en && is_sel);
        dp_n      = ~dp_mask[idx];
        an_next   = ~(8'h01 << idx);
        seg_next  = {dp_n, hex_seg};
        unique case (1'b1)
            blink_off: seg_next = SEG_OFF;
            blanked:   seg_next = {dp_n, SEG_BLANK};
            default:   seg_next = {dp_n, hex_seg};
        endcase
    end

    // Registered drivers update on the cycle after each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= AN_OFF;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_first;
            if (tick) begin
                an  <= an_next;
                seg <= seg_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display (SCAN_DIV=4, BLINK_HALF=2).
// Stimulus pushes expected slots; a monitor pops on each anode change.
module tb_seg7_scan_display;

    logic        clk;
    logic        rst_n;
    logic [31:0] data;
    logic [2:0]  sel;
    logic        blink_en;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    logic [16:0] sb_q[$];
    logic [7:0]  prev_an = 8'hFF;
    logic        check_fs = 1'b0;

    localparam logic [7:0] SCAN_SEG [8] = '{
        8'h8E, 8'hC0, 8'h88, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9
    };

    seg7_scan_display #(
        .SCAN_DIV   (4),
        .BLINK_HALF (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data        (data),
        .sel         (sel),
        .blink_en    (blink_en),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .an          (an),
        .seg         (seg),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] d, input logic [7:0] s);
        logic [7:0] a;
        a = ~(8'h01 << d);
        sb_q.push_back({(d == 3'd0), a, s});
    endtask

    task automatic start(input logic [31:0] d, input logic [2:0] sl,
                         input logic be, input logic bl,
                         input logic [7:0] dpm);
        @(negedge clk);
        rst_n = 1'b0;
        data = d; sel = sl; blink_en = be; blank_lz = bl; dp_mask = dpm;
        @(negedge clk);
        check("reset_an", {24'd0, an}, 32'hFF);
        check("reset_seg", {24'd0, seg}, 32'hFF);
        check("reset_fs", {31'd0, frame_start}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        check({name, "_queue_left"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: every new anode pattern is one displayed slot.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (check_fs) begin
                check("fs_one_cycle", {31'd0, frame_start}, 32'd0);
                check_fs = 1'b0;
            end
            if (rst_n === 1'b1 && an !== prev_an) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_slot: an=%h seg=%h", an, seg);
                end else begin
                    e = sb_q.pop_front();
                    check("slot", {15'd0, frame_start, an, seg},
                          {15'd0, e});
                    if (e[16]) check_fs = 1'b1;
                end
            end
            prev_an = an;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        data = '0; sel = '0; blink_en = 0; blank_lz = 0; dp_mask = '0;

        // Reset and first digit with latency check.
        start(32'h0000_0001, 3'd0, 1'b0, 1'b0, 8'h00);
        push(3'd0, 8'hF9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_first_an", {24'd0, an}, 32'hFF);
        repeat (3) @(posedge clk);
        drain("first");

        // Full scan over two frames.
        start(32'h1234_5A0F, 3'd0, 1'b0, 1'b0, 8'h00);
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 8; d++) push(3'(d), SCAN_SEG[d]);
        repeat (4 * 16 + 2) @(posedge clk);
        drain("scan");

        // Snapshot integrity: change data while digit 3 is shown.
        start(32'h1234_5A0F, 3'd0, 1'b0, 1'b0, 8'h00);
        for (int d = 0; d < 8; d++) push(3'(d), SCAN_SEG[d]);
        for (int d = 0; d < 8; d++) push(3'(d), 8'h8E);
        repeat (17) @(posedge clk);
        @(negedge clk);
        data = 32'hFFFF_FFFF;
        repeat (4 * 16 + 2 - 17) @(posedge clk);
        drain("snap");

        // Blink digit 3 over six frames with zero blanking.
        start(32'h0000_0000, 3'd3, 1'b1, 1'b1, 8'h00);
        for (int f = 0; f < 6; f++)
            for (int d = 0; d < 8; d++) begin
                if (d == 0) push(3'd0, 8'hC0);
                else if (d == 3) push(3'd3, (f == 2 || f == 3) ? 8'hFF : 8'hC0);
                else push(3'(d), 8'hFF);
            end
        repeat (4 * 48 + 2) @(posedge clk);
        drain("blink");

        // Leading-zero blanking with a decimal point.
        start(32'h0000_00A5, 3'd0, 1'b0, 1'b1, 8'h02);
        push(3'd0, 8'h92);
        push(3'd1, 8'h08);
        for (int d = 2; d < 8; d++) push(3'(d), 8'hFF);
        repeat (4 * 8 + 2) @(posedge clk);
        drain("lz");

        // Asynchronous reset while digit 5 is shown.
        start(32'h1234_5A0F, 3'd0, 1'b0, 1'b0, 8'h00);
        for (int d = 0; d < 6; d++) push(3'(d), SCAN_SEG[d]);
        repeat (24) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an", {24'd0, an}, 32'hFF);
        check("async_seg", {24'd0, seg}, 32'hFF);
        check("async_fs", {31'd0, frame_start}, 32'd0);
        drain("pre_async");
        @(negedge clk);
        rst_n = 1'b1;
        push(3'd0, 8'h8E);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("restart_wait_an", {24'd0, an}, 32'hFF);
        @(posedge clk);
        @(negedge clk);
        check("restart_an", {24'd0, an}, 32'hFE);
        repeat (2) @(posedge clk);
        drain("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
